// File: rtl/prescaled_updown_counter.sv
// Up/down counter that steps once every PRESCALE enabled clocks, with parallel load,
// a modulo limit of MAX_VALUE and a choice of wrap or saturate at the limits.
module prescaled_updown_counter #(
  parameter int DATA_WIDTH = 4,
  parameter int PRESCALE   = 4,
  parameter int MAX_VALUE  = 15,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  direction,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  step,
  output logic                  tc
);

  localparam int                    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]      PRE_ONE  = PRE_W'(1);
  localparam logic [DATA_WIDTH-1:0] MAX_CNT  = DATA_WIDTH'(MAX_VALUE);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);
  localparam logic                  SAT      = (SATURATE != 0);

  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  step_q, step_d;
  logic                  tc_q, tc_d;
  logic                  pre_term;

  // With PRESCALE=1 the phase register is stuck at 0, so every enabled cycle is terminal.
  assign pre_term = en && (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    step_d    = 1'b0;
    tc_d      = 1'b0;
    if (load) begin
      pre_cnt_d = '0;
      count_d   = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    end else if (en) begin
      if (pre_term) begin
        pre_cnt_d = '0;
        step_d    = 1'b1;
        if (direction) begin
          if (count_q >= MAX_CNT) begin
            tc_d    = 1'b1;
            count_d = SAT ? count_q : '0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          if (count_q == '0) begin
            tc_d    = 1'b1;
            count_d = SAT ? count_q : MAX_CNT;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pre_cnt_q <= '0;
      count_q   <= '0;
      step_q    <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      step_q    <= step_d;
      tc_q      <= tc_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Scoreboard bench: five differently configured counters share one stimulus stream and
// are compared each cycle against a phase/count reference model.
module tb_prescaled_updown_counter;

  localparam int N = 5;

  typedef struct packed {
    logic [N-1:0][7:0] cnt;
    logic [N-1:0]      stp;
    logic [N-1:0]      tcv;
  } expect_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       direction;
  logic       load;
  logic [7:0] load_value;

  logic [3:0]        count0, count1, count2, count3;
  logic [7:0]        count4;
  logic [N-1:0]      step_w, tc_w;
  logic [N-1:0][7:0] act_cnt;

  // Per-instance configuration mirrored in the reference model
  int cfg_w   [N] = '{4, 4, 4, 4, 8};
  int cfg_pre [N] = '{4, 4, 4, 1, 5};
  int cfg_max [N] = '{15, 9, 10, 15, 200};
  int cfg_sat [N] = '{0, 1, 0, 0, 1};

  int m_count [N];
  int m_phase [N];

  expect_t sb[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  prescaled_updown_counter #(.DATA_WIDTH(4), .PRESCALE(4), .MAX_VALUE(15), .SATURATE(0)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .direction(direction), .load(load),
    .load_value(load_value[3:0]), .count(count0), .step(step_w[0]), .tc(tc_w[0]));
  prescaled_updown_counter #(.DATA_WIDTH(4), .PRESCALE(4), .MAX_VALUE(9), .SATURATE(1)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .direction(direction), .load(load),
    .load_value(load_value[3:0]), .count(count1), .step(step_w[1]), .tc(tc_w[1]));
  prescaled_updown_counter #(.DATA_WIDTH(4), .PRESCALE(4), .MAX_VALUE(10), .SATURATE(0)) dut2 (
    .clk(clk), .rstn(rstn), .en(en), .direction(direction), .load(load),
    .load_value(load_value[3:0]), .count(count2), .step(step_w[2]), .tc(tc_w[2]));
  prescaled_updown_counter #(.DATA_WIDTH(4), .PRESCALE(1), .MAX_VALUE(15), .SATURATE(0)) dut3 (
    .clk(clk), .rstn(rstn), .en(en), .direction(direction), .load(load),
    .load_value(load_value[3:0]), .count(count3), .step(step_w[3]), .tc(tc_w[3]));
  prescaled_updown_counter #(.DATA_WIDTH(8), .PRESCALE(5), .MAX_VALUE(200), .SATURATE(1)) dut4 (
    .clk(clk), .rstn(rstn), .en(en), .direction(direction), .load(load),
    .load_value(load_value), .count(count4), .step(step_w[4]), .tc(tc_w[4]));

  assign act_cnt[0] = {4'b0000, count0};
  assign act_cnt[1] = {4'b0000, count1};
  assign act_cnt[2] = {4'b0000, count2};
  assign act_cnt[3] = {4'b0000, count3};
  assign act_cnt[4] = count4;

  // Drive one cycle of inputs, advance the reference model, queue the expected outputs
  task automatic applyStimulus(input bit r, input bit e, input bit d, input bit l,
                               input logic [7:0] v);
    expect_t ex;
    int lv;
    @(negedge clk);
    rstn = r; en = e; direction = d; load = l; load_value = v;
    ex = '0;
    for (int i = 0; i < N; i++) begin
      if (!r) begin
        m_count[i] = 0;
        m_phase[i] = 0;
      end else if (l) begin
        lv = int'(v) % (1 << cfg_w[i]);
        m_count[i] = (lv > cfg_max[i]) ? cfg_max[i] : lv;
        m_phase[i] = 0;
      end else if (e) begin
        m_phase[i] = (m_phase[i] + 1) % cfg_pre[i];
        if (m_phase[i] == 0) begin
          ex.stp[i] = 1'b1;
          if (d) begin
            if (m_count[i] == cfg_max[i]) begin
              ex.tcv[i] = 1'b1;
              if (cfg_sat[i] == 0) m_count[i] = 0;
            end else begin
              m_count[i] = m_count[i] + 1;
            end
          end else begin
            if (m_count[i] == 0) begin
              ex.tcv[i] = 1'b1;
              if (cfg_sat[i] == 0) m_count[i] = cfg_max[i];
            end else begin
              m_count[i] = m_count[i] - 1;
            end
          end
        end
      end
      ex.cnt[i] = 8'(m_count[i]);
    end
    sb.push_back(ex);
  endtask

  task automatic checkOutput(input expect_t ex);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (act_cnt[i] !== ex.cnt[i]) begin
        fails++;
        $display("[TB] FAIL count[%0d] t=%0t actual=%0d expected=%0d", i, $time, act_cnt[i], ex.cnt[i]);
      end else passed++;
      checks++;
      if (step_w[i] !== ex.stp[i]) begin
        fails++;
        $display("[TB] FAIL step[%0d] t=%0t actual=%b expected=%b", i, $time, step_w[i], ex.stp[i]);
      end else passed++;
      checks++;
      if (tc_w[i] !== ex.tcv[i]) begin
        fails++;
        $display("[TB] FAIL tc[%0d] t=%0t actual=%b expected=%b", i, $time, tc_w[i], ex.tcv[i]);
      end else passed++;
    end
  endtask

  // Monitor: the registered outputs are presented every clock, so one entry retires per edge
  always @(posedge clk) begin
    expect_t ex;
    #1;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      checkOutput(ex);
    end
  end

  initial begin
    int drain;
    rstn = 1'b0; en = 1'b0; direction = 1'b1; load = 1'b0; load_value = 8'd0;
    for (int i = 0; i < N; i++) begin
      m_count[i] = 0;
      m_phase[i] = 0;
    end

    $display("[TB] reset and count up");
    applyStimulus(0, 0, 1, 0, 8'd0);
    applyStimulus(0, 1, 1, 1, 8'd5);
    for (int k = 0; k < 70; k++) applyStimulus(1, 1, 1, 0, 8'd0);

    $display("[TB] count down through zero");
    for (int k = 0; k < 24; k++) applyStimulus(1, 1, 0, 0, 8'd0);

    $display("[TB] load at limit, count up into saturation");
    applyStimulus(1, 1, 1, 1, 8'd9);
    for (int k = 0; k < 12; k++) applyStimulus(1, 1, 1, 0, 8'd0);

    $display("[TB] gated enable pattern");
    applyStimulus(1, 0, 1, 1, 8'd0);
    applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(1, 0, 1, 0, 8'd0);
    applyStimulus(1, 0, 1, 0, 8'd0);
    applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(1, 0, 1, 0, 8'd0);

    $display("[TB] load over limit on a step edge");
    applyStimulus(1, 1, 1, 1, 8'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(1, 1, 1, 1, 8'd13);
    for (int k = 0; k < 5; k++) applyStimulus(1, 1, 1, 0, 8'd0);

    $display("[TB] reset mid-count with load asserted");
    applyStimulus(1, 1, 1, 1, 8'd7);
    applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(1, 1, 1, 0, 8'd0);
    applyStimulus(0, 1, 1, 1, 8'd12);
    for (int k = 0; k < 6; k++) applyStimulus(1, 1, 1, 0, 8'd0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 80),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 4),
                    8'($urandom_range(0, 255)));
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain outstanding=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
